ex_pipe_stage: RTL and testbench

//  - ID/EX pipeline register, operand forwarding mux and ALU of the 5-stage RV64 pipeline.
//  - Captures decoded operands and control each cycle; combinationally forwards from EX/MEM or MEM/WB.
//  - Computes the ALU result and zero flag, and passes MEM/WB control and the store data toward EX/MEM.

---
 rtl/ex_pkg.sv | 60 ++++++
 rtl/ex_pipe_stage_if.sv | 22 ++
 rtl/ex_alu.sv | 40 ++++
 rtl/ex_pipe_stage.sv | 135 +++++++++++++
 tb/tb_ex_pipe_stage.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the EX stage.
// ALU control codes, ALU-op classes, forwarding selects, ID/EX bundle.
package ex_pkg;

  localparam int XLEN = 64;
  localparam int RA_W = 5;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic            branch;
    logic            mem_read;
    logic            mem_to_reg;
    logic            mem_write;
    logic            alu_src;
    logic            reg_write;
    logic [1:0]      alu_op;
    logic [2:0]      func3;
    logic            func7b5;
  } id_ex_t;

  function automatic logic [1:0] fwd_sel(
    input logic            em_wr,
    input logic [RA_W-1:0] em_rd,
    input logic            mw_wr,
    input logic [RA_W-1:0] mw_rd,
    input logic [RA_W-1:0] rs
  );
    if (em_wr && em_rd != '0 && em_rd == rs)
      return FWD_EXMEM;
    if (mw_wr && mw_rd != '0 && mw_rd == rs)
      return FWD_MEMWB;
    return FWD_IDEX;
  endfunction

endpackage

// File: rtl/ex_pipe_stage_if.sv
// Forwarding bus from the EX/MEM and MEM/WB registers into EX.
// The later stages drive it (master); the EX stage samples it (slave).
interface ex_pipe_stage_if;
  import ex_pkg::*;

  logic [RA_W-1:0] exmem_rd;
  logic            exmem_reg_write;
  logic [XLEN-1:0] exmem_alu_result;
  logic [RA_W-1:0] memwb_rd;
  logic            memwb_reg_write;
  logic [XLEN-1:0] memwb_wdata;

  modport master (
    output exmem_rd, exmem_reg_write, exmem_alu_result,
    output memwb_rd, memwb_reg_write, memwb_wdata
  );

  modport slave (
    input exmem_rd, exmem_reg_write, exmem_alu_result,
    input memwb_rd, memwb_reg_write, memwb_wdata
  );
endinterface

// File: rtl/ex_alu.sv
// RV64 integer ALU: combinational result and zero flag.
// Undefined control codes yield 0.
module ex_alu
  import ex_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [5:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[5:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    unique case (alu_ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SUB:  result = a - b;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_pipe_stage.sv
// ID/EX register, operand forwarding and ALU for the RV64 pipeline.
// Flush loads an all-zero bundle, which decodes as a NOP.
module ex_pipe_stage
  import ex_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               idex_flush,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [RA_W-1:0]    id_rs1,
  input  logic [RA_W-1:0]    id_rs2,
  input  logic [RA_W-1:0]    id_rd,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_branch,
  input  logic               id_mem_read,
  input  logic               id_mem_to_reg,
  input  logic               id_mem_write,
  input  logic               id_alu_src,
  input  logic               id_reg_write,
  input  logic [1:0]         id_alu_op,
  input  logic [2:0]         id_func3,
  input  logic               id_func7b5,
  ex_pipe_stage_if.slave     fwd,
  output logic [XLEN-1:0]    alu_result,
  output logic               alu_zero,
  output logic [3:0]         alu_ctrl,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [RA_W-1:0]    ex_rd,
  output logic               ex_branch,
  output logic               ex_mem_read,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_write,
  output logic               ex_reg_write
);

  id_ex_t idex_d;
  id_ex_t idex_q;

  always_comb begin
    idex_d = '0;
    if (!idex_flush) begin
      idex_d.rs1_data   = id_rs1_data;
      idex_d.rs2_data   = id_rs2_data;
      idex_d.imm        = id_imm;
      idex_d.rs1        = id_rs1;
      idex_d.rs2        = id_rs2;
      idex_d.rd         = id_rd;
      idex_d.branch     = id_branch;
      idex_d.mem_read   = id_mem_read;
      idex_d.mem_to_reg = id_mem_to_reg;
      idex_d.mem_write  = id_mem_write;
      idex_d.alu_src    = id_alu_src;
      idex_d.reg_write  = id_reg_write;
      idex_d.alu_op     = id_alu_op;
      idex_d.func3      = id_func3;
      idex_d.func7b5    = id_func7b5;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  assign forward_a = fwd_sel(fwd.exmem_reg_write, fwd.exmem_rd,
                             fwd.memwb_reg_write, fwd.memwb_rd,
                             idex_q.rs1);
  assign forward_b = fwd_sel(fwd.exmem_reg_write, fwd.exmem_rd,
                             fwd.memwb_reg_write, fwd.memwb_rd,
                             idex_q.rs2);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] rs2_fwd;

  always_comb begin
    op_a    = idex_q.rs1_data;
    rs2_fwd = idex_q.rs2_data;
    unique case (forward_a)
      FWD_EXMEM: op_a = fwd.exmem_alu_result;
      FWD_MEMWB: op_a = fwd.memwb_wdata;
      default:   op_a = idex_q.rs1_data;
    endcase
    unique case (forward_b)
      FWD_EXMEM: rs2_fwd = fwd.exmem_alu_result;
      FWD_MEMWB: rs2_fwd = fwd.memwb_wdata;
      default:   rs2_fwd = idex_q.rs2_data;
    endcase
  end

  // funct7[5] selects SUB only for R-type; for I-type it marks SRAI
  always_comb begin
    alu_ctrl = ALU_ADD;
    unique case (idex_q.alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        unique case (idex_q.func3)
          3'b000: alu_ctrl =
            (idex_q.alu_op == ALUOP_RTYPE && idex_q.func7b5)
            ? ALU_SUB : ALU_ADD;
          3'b001: alu_ctrl = ALU_SLL;
          3'b010: alu_ctrl = ALU_SLT;
          3'b011: alu_ctrl = ALU_SLTU;
          3'b100: alu_ctrl = ALU_XOR;
          3'b101: alu_ctrl =
            idex_q.func7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  ex_alu u_alu (
    .a        (op_a),
    .b        (idex_q.alu_src ? idex_q.imm : rs2_fwd),
    .alu_ctrl (alu_ctrl),
    .result   (alu_result),
    .zero     (alu_zero)
  );

  assign ex_store_data = rs2_fwd;
  assign ex_imm        = idex_q.imm;
  assign ex_rd         = idex_q.rd;
  assign ex_branch     = idex_q.branch;
  assign ex_mem_read   = idex_q.mem_read;
  assign ex_mem_to_reg = idex_q.mem_to_reg;
  assign ex_mem_write  = idex_q.mem_write;
  assign ex_reg_write  = idex_q.reg_write;

endmodule

// File: tb/tb_ex_pipe_stage.sv
// Bench for ex_pipe_stage: directed cases plus random
// traffic against a behavioural model of the EX stage.
module tb_ex_pipe_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            flush;
  logic [63:0]     rs1_data, rs2_data, imm;
  logic [4:0]      rs1, rs2, rd;
  logic            branch, mem_read, mem_to_reg;
  logic            mem_write, alu_src, reg_write;
  logic [1:0]      alu_op;
  logic [2:0]      f3;
  logic            f7;

  logic [63:0]     alu_result, ex_store_data, ex_imm;
  logic            alu_zero;
  logic [3:0]      alu_ctrl;
  logic [1:0]      forward_a, forward_b;
  logic [4:0]      ex_rd;
  logic            ex_branch, ex_mem_read, ex_mem_to_reg;
  logic            ex_mem_write, ex_reg_write;

  ex_pipe_stage_if f ();

  ex_pipe_stage dut (
    .clk              (clk),
    .rst              (rst),
    .idex_flush       (flush),
    .id_rs1_data      (rs1_data),
    .id_rs2_data      (rs2_data),
    .id_rs1           (rs1),
    .id_rs2           (rs2),
    .id_rd            (rd),
    .id_imm           (imm),
    .id_branch        (branch),
    .id_mem_read      (mem_read),
    .id_mem_to_reg    (mem_to_reg),
    .id_mem_write     (mem_write),
    .id_alu_src       (alu_src),
    .id_reg_write     (reg_write),
    .id_alu_op        (alu_op),
    .id_func3         (f3),
    .id_func7b5       (f7),
    .fwd              (f),
    .alu_result       (alu_result),
    .alu_zero         (alu_zero),
    .alu_ctrl         (alu_ctrl),
    .forward_a        (forward_a),
    .forward_b        (forward_b),
    .ex_store_data    (ex_store_data),
    .ex_imm           (ex_imm),
    .ex_rd            (ex_rd),
    .ex_branch        (ex_branch),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .ex_mem_write     (ex_mem_write),
    .ex_reg_write     (ex_reg_write)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic clr_id();
    flush = 0; rs1_data = 0; rs2_data = 0; imm = 0;
    rs1 = 0; rs2 = 0; rd = 0;
    branch = 0; mem_read = 0; mem_to_reg = 0;
    mem_write = 0; alu_src = 0; reg_write = 0;
    alu_op = 0; f3 = 0; f7 = 0;
  endtask

  task automatic clr_fwd();
    f.exmem_rd = 0; f.exmem_reg_write = 0; f.exmem_alu_result = 0;
    f.memwb_rd = 0; f.memwb_reg_write = 0; f.memwb_wdata = 0;
  endtask

  task automatic rnd_id();
    rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom};
    imm = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) rs2_data = {58'd0, rs2_data[5:0]};
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    rd = 5'($urandom);
    {branch, mem_read, mem_to_reg} = 3'($urandom);
    {mem_write, alu_src, reg_write} = 3'($urandom);
    alu_op = 2'($urandom);
    f3 = 3'($urandom);
    f7 = 1'($urandom);
  endtask

  task automatic rnd_fwd();
    f.exmem_rd = 5'($urandom_range(0, 3));
    f.exmem_reg_write = 1'($urandom);
    f.exmem_alu_result = {$urandom, $urandom};
    f.memwb_rd = 5'($urandom_range(0, 3));
    f.memwb_reg_write = 1'($urandom);
    f.memwb_wdata = {$urandom, $urandom};
  endtask

  // Reference: which stage supplies a source register
  function automatic logic [1:0] m_sel(logic [4:0] r);
    if (r == 0) return 2'b00;
    if (f.exmem_reg_write && f.exmem_rd == r) return 2'b10;
    if (f.memwb_reg_write && f.memwb_rd == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [63:0] m_val(logic [4:0] r, logic [63:0] d);
    logic [1:0] s;
    s = m_sel(r);
    if (s == 2'b10) return f.exmem_alu_result;
    if (s == 2'b01) return f.memwb_wdata;
    return d;
  endfunction

  // Reference ALU from the operation table, by mnemonic
  task automatic m_alu(input logic [1:0] op, input logic [2:0] fn,
                       input logic f75, input logic [63:0] a,
                       input logic [63:0] b, output logic [3:0] c,
                       output logic [63:0] r);
    int sh;
    sh = int'(b % 64);
    if (op == 2'd0) begin c = 4'd2; r = a + b; end
    else if (op == 2'd1) begin c = 4'd6; r = a - b; end
    else begin
      case (fn)
        3'd0: if (op == 2'd2 && f75) begin c = 4'd6; r = a - b; end
              else begin c = 4'd2; r = a + b; end
        3'd1: begin c = 4'd4; r = a << sh; end
        3'd2: begin c = 4'd8; r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0; end
        3'd3: begin c = 4'd9; r = (a < b) ? 64'd1 : 64'd0; end
        3'd4: begin c = 4'd3; r = a ^ b; end
        3'd5: if (f75) begin c = 4'd7; r = $unsigned($signed(a) >>> sh); end
              else begin c = 4'd5; r = a >> sh; end
        3'd6: begin c = 4'd1; r = a | b; end
        default: begin c = 4'd0; r = a & b; end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] s_rs1d, s_rs2d, s_imm, a, b, st, er;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [5:0]  s_ctl;
    logic [1:0]  s_op;
    logic [2:0]  s_f3;
    logic        s_f7, s_src;
    logic [3:0]  ec;

    clr_fwd();
    rst = 0;
    rnd_id();
    step(); step();
    rst = 1;
    clr_id();
    chk("rst_rd", 64'(ex_rd), 0);
    chk("rst_ctl", 64'({ex_branch, ex_mem_read, ex_mem_to_reg,
                        ex_mem_write, ex_reg_write}), 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_res", alu_result, 0);
    chk("rst_zero", 64'(alu_zero), 1);

    rs1_data = 7; rs2_data = 5; alu_op = 2; f3 = 0; f7 = 1;
    step();
    chk("sub_ctl", 64'(alu_ctrl), 6);
    chk("sub_res", alu_result, 2);
    rs1_data = 5;
    step();
    chk("sub0_res", alu_result, 0);
    chk("sub0_zero", 64'(alu_zero), 1);

    clr_id();
    alu_op = 3; f3 = 0; f7 = 1; alu_src = 1; imm = -64'sd3; rs1_data = 10;
    step();
    chk("addi_ctl", 64'(alu_ctrl), 2);
    chk("addi_res", alu_result, 7);

    clr_id();
    alu_op = 2; f3 = 5; f7 = 1; rs1_data = -64'sd16; rs2_data = 2;
    step();
    chk("sra_ctl", 64'(alu_ctrl), 7);
    chk("sra_res", alu_result, -64'sd4);

    clr_id();
    alu_op = 2; f3 = 3; rs1_data = -64'sd1; rs2_data = 1;
    step();
    chk("sltu_res", alu_result, 0);
    f3 = 2;
    step();
    chk("slt_res", alu_result, 1);

    clr_id();
    rs1 = 3; rs2 = 3; rs1_data = 1; rs2_data = 2;
    f.exmem_rd = 3; f.exmem_reg_write = 1; f.exmem_alu_result = 100;
    f.memwb_rd = 3; f.memwb_reg_write = 1; f.memwb_wdata = 200;
    step();
    chk("fwd_a_em", 64'(forward_a), 2);
    chk("fwd_b_em", 64'(forward_b), 2);
    chk("fwd_em_res", alu_result, 200);
    f.exmem_reg_write = 0; #1;
    chk("fwd_a_mw", 64'(forward_a), 1);
    chk("fwd_b_mw", 64'(forward_b), 1);
    chk("fwd_mw_res", alu_result, 400);
    f.exmem_rd = 0; f.memwb_rd = 0; f.exmem_reg_write = 1; #1;
    chk("fwd_a_x0", 64'(forward_a), 0);
    chk("fwd_b_x0", 64'(forward_b), 0);
    chk("fwd_x0_res", alu_result, 3);

    clr_id(); clr_fwd();
    alu_src = 1; imm = 8; rs1_data = 16; rs2 = 4; rs2_data = 9;
    mem_write = 1; rd = 0;
    f.memwb_rd = 4; f.memwb_reg_write = 1; f.memwb_wdata = 55;
    step();
    chk("sw_res", alu_result, 24);
    chk("sw_data", ex_store_data, 55);
    chk("sw_memw", 64'(ex_mem_write), 1);
    flush = 1; rd = 9; reg_write = 1; branch = 1; mem_read = 1;
    step();
    chk("fl_ctl", 64'({ex_branch, ex_mem_read, ex_mem_to_reg,
                       ex_mem_write, ex_reg_write}), 0);
    chk("fl_rd", 64'(ex_rd), 0);
    chk("fl_imm", ex_imm, 0);

    for (int i = 0; i < 300; i++) begin
      rnd_id(); rnd_fwd();
      flush = ($urandom_range(0, 7) == 0);
      step();
      if (flush) begin
        {s_rs1d, s_rs2d, s_imm} = '0;
        {s_rs1, s_rs2, s_rd, s_ctl, s_op, s_f3, s_f7, s_src} = '0;
      end else begin
        s_rs1d = rs1_data; s_rs2d = rs2_data; s_imm = imm;
        s_rs1 = rs1; s_rs2 = rs2; s_rd = rd;
        s_ctl = {branch, mem_read, mem_to_reg, mem_write, reg_write, 1'b0};
        s_op = alu_op; s_f3 = f3; s_f7 = f7; s_src = alu_src;
      end
      rnd_fwd(); rnd_id(); #1;
      a = m_val(s_rs1, s_rs1d);
      st = m_val(s_rs2, s_rs2d);
      b = s_src ? s_imm : st;
      m_alu(s_op, s_f3, s_f7, a, b, ec, er);
      chk("r_fa", 64'(forward_a), 64'(m_sel(s_rs1)));
      chk("r_fb", 64'(forward_b), 64'(m_sel(s_rs2)));
      chk("r_ctl", 64'(alu_ctrl), 64'(ec));
      chk("r_res", alu_result, er);
      chk("r_zero", 64'(alu_zero), 64'(er == 0));
      chk("r_st", ex_store_data, st);
      chk("r_imm", ex_imm, s_imm);
      chk("r_rd", 64'(ex_rd), 64'(s_rd));
      chk("r_cv", 64'({ex_branch, ex_mem_read, ex_mem_to_reg,
                       ex_mem_write, ex_reg_write, 1'b0}), 64'(s_ctl));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
